// File: rtl/wb_pkg.sv
// Shared types for the writeback/retire stage.
// Load-type codes and the debug trace entry layout.
package wb_pkg;

  localparam logic [2:0] LD_LB  = 3'd0;
  localparam logic [2:0] LD_LBU = 3'd1;
  localparam logic [2:0] LD_LH  = 3'd2;
  localparam logic [2:0] LD_LHU = 3'd3;
  localparam logic [2:0] LD_LW  = 3'd4;
  localparam logic [2:0] LD_LWU = 3'd5;
  localparam logic [2:0] LD_LD  = 3'd6;

  typedef struct packed {
    logic [31:0] pc;
    logic        wen;
    logic [4:0]  wnum;
    logic [31:0] wdata;
  } trace_entry_t;

endpackage

// File: rtl/load_extend.sv
// Combinational load aligner/extender for one retire lane.
// Misaligned or unsupported loads return zero.
module load_extend
  import wb_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] raw,
  input  logic [2:0]        addr_lo,
  input  logic [2:0]        ld_type,
  output logic [DATA_W-1:0] val
);

  logic              wide;
  logic [2:0]        off;
  logic [DATA_W-1:0] sh;

  assign wide = (DATA_W == 64);
  // Offset bit 2 only exists in a 64-bit word.
  assign off  = wide ? addr_lo : {1'b0, addr_lo[1:0]};
  assign sh   = raw >> {off, 3'b000};

  always_comb begin
    val = '0;
    unique case (ld_type)
      LD_LB:  val = DATA_W'($signed(sh[7:0]));
      LD_LBU: val = DATA_W'(sh[7:0]);
      LD_LH:
        if (!off[0]) val = DATA_W'($signed(sh[15:0]));
      LD_LHU:
        if (!off[0]) val = DATA_W'(sh[15:0]);
      LD_LW:
        if (off[1:0] == 2'd0)
          val = DATA_W'($signed(sh[31:0]));
      LD_LWU:
        if (wide && off[1:0] == 2'd0)
          val = DATA_W'(sh[31:0]);
      LD_LD:
        if (wide && off == 3'd0) val = sh;
      default: val = '0;
    endcase
  end

endmodule

// File: rtl/wb_retire_unit.sv
// Multi-lane writeback/retire stage with regfile ports
// and an in-order debug trace FIFO.
module wb_retire_unit
  import wb_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int LANES       = 2,
  parameter int TRACE_DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES-1:0]         lane_valid,
  input  logic [32*LANES-1:0]      lane_pc,
  input  logic [LANES-1:0]         lane_wren,
  input  logic [5*LANES-1:0]       lane_waddr,
  input  logic [LANES-1:0]         lane_mem2reg,
  input  logic [DATA_W*LANES-1:0]  lane_alu_val,
  input  logic [DATA_W*LANES-1:0]  lane_load_raw,
  input  logic [3*LANES-1:0]       lane_addr_lo,
  input  logic [3*LANES-1:0]       lane_ld_type,
  output logic [LANES-1:0]         rf_we,
  output logic [5*LANES-1:0]       rf_waddr,
  output logic [DATA_W*LANES-1:0]  rf_wdata,
  output logic [31:0]              debug_wb_pc,
  output logic [3:0]               debug_wb_rf_wen,
  output logic [4:0]               debug_wb_rf_wnum,
  output logic [31:0]              debug_wb_rf_wdata
);

  localparam int AW = $clog2(TRACE_DEPTH);
  localparam int CW = AW + 1;

  trace_entry_t fifo_q [TRACE_DEPTH];
  trace_entry_t ent [LANES];
  trace_entry_t dbg_d, dbg_q;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] slot [LANES];
  logic [CW-1:0] count_q, count_d, npush;

  logic [LANES-1:0]        we_raw, push_en;
  logic [LANES-1:0]        rf_we_q, rf_we_d;
  logic [5*LANES-1:0]      rf_waddr_q;
  logic [DATA_W*LANES-1:0] rf_wdata_q, data_d;
  logic [DATA_W-1:0]       ext [LANES];
  logic                    accept, pop;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    load_extend #(.DATA_W(DATA_W)) u_ext (
      .raw     (lane_load_raw[g*DATA_W +: DATA_W]),
      .addr_lo (lane_addr_lo[g*3 +: 3]),
      .ld_type (lane_ld_type[g*3 +: 3]),
      .val     (ext[g])
    );
  end

  // Ready depends on registered count only: room for a full bundle.
  assign in_ready = count_q <= CW'(TRACE_DEPTH - LANES);
  assign accept   = in_valid & in_ready;
  assign pop      = count_q != '0;

  always_comb begin
    we_raw  = '0;
    data_d  = '0;
    rf_we_d = '0;
    push_en = '0;
    npush   = '0;
    for (int i = 0; i < LANES; i++) begin
      we_raw[i] = lane_valid[i] & lane_wren[i]
                & (lane_waddr[i*5 +: 5] != 5'd0);
      data_d[i*DATA_W +: DATA_W] = lane_mem2reg[i]
        ? ext[i] : lane_alu_val[i*DATA_W +: DATA_W];
    end
    // A younger lane to the same register masks the older write.
    for (int i = 0; i < LANES; i++) begin
      rf_we_d[i] = accept & we_raw[i];
      for (int j = i + 1; j < LANES; j++)
        if (we_raw[j] &&
            lane_waddr[j*5 +: 5] == lane_waddr[i*5 +: 5])
          rf_we_d[i] = 1'b0;
    end
    for (int i = 0; i < LANES; i++) begin
      slot[i]    = wr_ptr_q + npush[AW-1:0];
      push_en[i] = accept & lane_valid[i];
      ent[i]     = '{pc:    lane_pc[i*32 +: 32],
                     wen:   we_raw[i],
                     wnum:  lane_waddr[i*5 +: 5],
                     wdata: data_d[i*DATA_W +: 32]};
      if (push_en[i]) npush = npush + CW'(1);
    end
    count_d  = count_q + npush - CW'(pop);
    wr_ptr_d = wr_ptr_q + npush[AW-1:0];
    rd_ptr_d = rd_ptr_q + AW'(pop);
    dbg_d    = pop ? fifo_q[rd_ptr_q] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rf_we_q    <= '0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      dbg_q      <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rf_we_q  <= rf_we_d;
      if (accept) begin
        rf_waddr_q <= lane_waddr;
        rf_wdata_q <= data_d;
      end
      dbg_q <= dbg_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++)
      if (push_en[i]) fifo_q[slot[i]] <= ent[i];
  end

  assign rf_we             = rf_we_q;
  assign rf_waddr          = rf_waddr_q;
  assign rf_wdata          = rf_wdata_q;
  assign debug_wb_pc       = dbg_q.pc;
  assign debug_wb_rf_wen   = {4{dbg_q.wen}};
  assign debug_wb_rf_wnum  = dbg_q.wnum;
  assign debug_wb_rf_wdata = dbg_q.wdata;

endmodule

// File: tb/tb_wb_retire_unit.sv
// Scoreboard bench for wb_retire_unit: 32-bit dual-lane
// instance plus a 64-bit single-lane instance.
module tb_wb_retire_unit;
  import wb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid, in_ready;
  logic [1:0]  lane_valid, lane_wren, lane_mem2reg;
  logic [63:0] lane_pc, lane_alu_val, lane_load_raw;
  logic [9:0]  lane_waddr;
  logic [5:0]  lane_addr_lo, lane_ld_type;
  logic [1:0]  rf_we;
  logic [9:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic [31:0] dpc, dwdata;
  logic [3:0]  dwen;
  logic [4:0]  dwnum;

  wb_retire_unit #(.DATA_W(32), .LANES(2), .TRACE_DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .lane_valid(lane_valid), .lane_pc(lane_pc),
    .lane_wren(lane_wren), .lane_waddr(lane_waddr),
    .lane_mem2reg(lane_mem2reg), .lane_alu_val(lane_alu_val),
    .lane_load_raw(lane_load_raw), .lane_addr_lo(lane_addr_lo),
    .lane_ld_type(lane_ld_type),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .debug_wb_pc(dpc), .debug_wb_rf_wen(dwen),
    .debug_wb_rf_wnum(dwnum), .debug_wb_rf_wdata(dwdata)
  );

  logic        x_valid, x_ready;
  logic [0:0]  x_lv, x_wren, x_m2r, x_we;
  logic [31:0] x_pc, x_dpc, x_dwdata;
  logic [4:0]  x_wa, x_waddr, x_dwnum;
  logic [63:0] x_alu, x_raw, x_wdata;
  logic [2:0]  x_lo, x_ty;
  logic [3:0]  x_dwen;

  wb_retire_unit #(.DATA_W(64), .LANES(1), .TRACE_DEPTH(4)) dut64 (
    .clk(clk), .rst(rst),
    .in_valid(x_valid), .in_ready(x_ready),
    .lane_valid(x_lv), .lane_pc(x_pc),
    .lane_wren(x_wren), .lane_waddr(x_wa),
    .lane_mem2reg(x_m2r), .lane_alu_val(x_alu),
    .lane_load_raw(x_raw), .lane_addr_lo(x_lo),
    .lane_ld_type(x_ty),
    .rf_we(x_we), .rf_waddr(x_waddr), .rf_wdata(x_wdata),
    .debug_wb_pc(x_dpc), .debug_wb_rf_wen(x_dwen),
    .debug_wb_rf_wnum(x_dwnum), .debug_wb_rf_wdata(x_dwdata)
  );

  typedef struct packed {
    bit v; bit [31:0] pc; bit wren; bit [4:0] wa; bit m2r;
    bit [31:0] alu; bit [31:0] raw; bit [2:0] lo; bit [2:0] ty;
    bit [31:0] exp;
  } lane_t;

  typedef struct packed {
    bit [1:0] we; bit [9:0] wa; bit [63:0] d;
  } rf_exp_t;

  typedef struct packed {
    bit [31:0] pc; bit [3:0] wen; bit [4:0] wnum; bit [31:0] wdata;
  } tr_t;

  lane_t   ln [2];
  bit      vin;
  rf_exp_t rfq [$];
  tr_t     trq [$];
  int      n_chk, n_fail;
  bit      seen_block;
  int      bp_push;

  task automatic chk(string tag, logic [127:0] act,
                     logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic lane_t mk(bit [31:0] pc, bit [4:0] wa,
      bit m2r, bit [31:0] alu, bit [31:0] raw, bit [2:0] lo,
      bit [2:0] ty, bit [31:0] exp);
    lane_t l;
    l = '{v: 1'b1, pc: pc, wren: 1'b1, wa: wa, m2r: m2r,
          alu: alu, raw: raw, lo: lo, ty: ty, exp: exp};
    return l;
  endfunction

  task automatic apply();
    in_valid = vin;
    for (int i = 0; i < 2; i++) begin
      lane_valid[i]            = ln[i].v;
      lane_pc[i*32 +: 32]      = ln[i].pc;
      lane_wren[i]             = ln[i].wren;
      lane_waddr[i*5 +: 5]     = ln[i].wa;
      lane_mem2reg[i]          = ln[i].m2r;
      lane_alu_val[i*32 +: 32] = ln[i].alu;
      lane_load_raw[i*32 +: 32]= ln[i].raw;
      lane_addr_lo[i*3 +: 3]   = ln[i].lo;
      lane_ld_type[i*3 +: 3]   = ln[i].ty;
    end
  endtask

  // One clock of the 32-bit instance with scoreboard push/pop.
  task automatic step();
    bit rdy, pop;
    bit [1:0] wr;
    rf_exp_t e, g;
    tr_t t;
    apply();
    rdy = trq.size() <= 6;
    pop = trq.size() != 0;
    chk("in_ready", 128'(in_ready), 128'(rdy));
    if (!rdy) seen_block = 1'b1;
    e = '0;
    if (vin && rdy) begin
      for (int i = 0; i < 2; i++)
        wr[i] = ln[i].v && ln[i].wren && ln[i].wa != 5'd0;
      e.we = wr;
      if (wr[0] && wr[1] && ln[0].wa == ln[1].wa) e.we[0] = 1'b0;
      for (int i = 0; i < 2; i++) begin
        e.wa[i*5 +: 5] = ln[i].wa;
        e.d[i*32 +: 32] = ln[i].exp;
        if (ln[i].v) begin
          trq.push_back('{ln[i].pc, {4{wr[i]}}, ln[i].wa,
                          ln[i].exp});
          bp_push++;
        end
      end
    end
    rfq.push_back(e);
    @(posedge clk);
    #1;
    g = rfq.pop_front();
    chk("rf_we", 128'(rf_we), 128'(g.we));
    for (int i = 0; i < 2; i++)
      if (g.we[i]) begin
        chk("rf_waddr", 128'(rf_waddr[i*5 +: 5]),
            128'(g.wa[i*5 +: 5]));
        chk("rf_wdata", 128'(rf_wdata[i*32 +: 32]),
            128'(g.d[i*32 +: 32]));
      end
    if (pop) begin
      t = trq.pop_front();
      chk("trace", 128'({dpc, dwen, dwnum, dwdata}), 128'(t));
    end else
      chk("trace_idle", 128'({dpc, dwen, dwnum, dwdata}), 128'(0));
  endtask

  localparam logic [31:0] RAW = 32'h80FF7F01;
  localparam logic [63:0] XRAW = 64'h8000000012345678;

  logic [2:0]  xlo [5];
  logic [2:0]  xty [5];
  logic [63:0] xexp [5];

  initial begin
    n_chk = 0; n_fail = 0; seen_block = 0; bp_push = 0;
    rst = 1'b1; vin = 1'b0;
    ln[0] = '0; ln[1] = '0;
    x_valid = 0; x_lv = 1; x_pc = 32'h2000; x_wren = 1;
    x_wa = 5'd7; x_m2r = 1; x_alu = '0; x_raw = XRAW;
    x_lo = 0; x_ty = 0;
    apply();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_rf_we", 128'(rf_we), 128'(0));
    chk("rst_rf_waddr", 128'(rf_waddr), 128'(0));
    chk("rst_rf_wdata", 128'(rf_wdata), 128'(0));
    chk("rst_trace", 128'({dpc, dwen, dwnum, dwdata}), 128'(0));
    chk("rst_ready", 128'(in_ready), 128'(1));
    chk("rst_ready64", 128'(x_ready), 128'(1));

    // Load extension, single lane.
    vin = 1'b1;
    ln[1] = '0;
    ln[0] = mk(32'h100, 1, 1, 0, RAW, 3'd1, LD_LB,  32'h0000007F);
    step();
    ln[0] = mk(32'h104, 2, 1, 0, RAW, 3'd3, LD_LB,  32'hFFFFFF80);
    step();
    ln[0] = mk(32'h108, 3, 1, 0, RAW, 3'd2, LD_LHU, 32'h000080FF);
    step();
    ln[0] = mk(32'h10C, 4, 1, 0, RAW, 3'd1, LD_LH,  32'h0);
    step();
    ln[0] = mk(32'h110, 5, 1, 0, RAW, 3'd2, LD_LH,  32'hFFFF80FF);
    step();
    ln[0] = mk(32'h114, 6, 1, 0, RAW, 3'd2, LD_LBU, 32'h000000FF);
    step();
    ln[0] = mk(32'h118, 7, 1, 0, RAW, 3'd0, LD_LW,  RAW);
    step();
    ln[0] = mk(32'h11C, 8, 1, 0, RAW, 3'd2, LD_LW,  32'h0);
    step();
    ln[0] = mk(32'h120, 9, 1, 0, RAW, 3'd5, LD_LB,  32'h0000007F);
    step();
    ln[0] = mk(32'h124, 10, 1, 0, RAW, 3'd0, LD_LWU, 32'h0);
    step();
    ln[0] = mk(32'h128, 11, 0, 32'hDEADBEEF, RAW, 3'd1, LD_LH,
               32'hDEADBEEF);
    step();

    // Same-register conflict, r0 write, lane1-only, distinct regs.
    ln[0] = mk(32'h200, 5, 0, 32'h11, 0, 0, 0, 32'h11);
    ln[1] = mk(32'h204, 5, 0, 32'h22, 0, 0, 0, 32'h22);
    step();
    ln[0] = mk(32'h300, 0, 0, 32'h55, 0, 0, 0, 32'h55);
    ln[1] = '0;
    step();
    ln[0] = '0;
    ln[1] = mk(32'h400, 9, 0, 32'h99, 0, 0, 0, 32'h99);
    step();
    ln[0] = mk(32'h500, 3, 0, 32'hA3, 0, 0, 0, 32'hA3);
    ln[1] = mk(32'h504, 4, 1, 0, RAW, 3'd3, LD_LBU, 32'h80);
    step();
    vin = 1'b0;
    repeat (10) step();

    // Back-pressure with full bundles every cycle.
    bp_push = 0;
    vin = 1'b1;
    for (int k = 0; k < 14; k++) begin
      logic [31:0] a0, a1;
      a0 = $urandom; a1 = $urandom;
      ln[0] = mk(32'h1000 + 8*k, 5'($urandom_range(1, 31)), 0,
                 a0, 0, 0, 0, a0);
      ln[1] = mk(32'h1004 + 8*k, 5'($urandom_range(1, 31)), 0,
                 a1, 0, 0, 0, a1);
      step();
    end
    chk("bp_throttle", 128'(seen_block), 128'(1));
    chk("bp_wrap", 128'(bp_push >= 16), 128'(1));
    vin = 1'b0;
    repeat (16) step();

    // Reset with five entries pending.
    vin = 1'b1;
    for (int k = 0; k < 4; k++) begin
      ln[0] = mk(32'h3000 + 8*k, 12, 0, 32'h77, 0, 0, 0, 32'h77);
      ln[1] = mk(32'h3004 + 8*k, 13, 0, 32'h78, 0, 0, 0, 32'h78);
      step();
    end
    vin = 1'b0;
    apply();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    rfq.delete();
    trq.delete();
    chk("mrst_rf_we", 128'(rf_we), 128'(0));
    chk("mrst_rf_waddr", 128'(rf_waddr), 128'(0));
    chk("mrst_rf_wdata", 128'(rf_wdata), 128'(0));
    chk("mrst_trace", 128'({dpc, dwen, dwnum, dwdata}), 128'(0));
    repeat (4) step();

    // 64-bit instance.
    xlo[0] = 3'd4; xty[0] = LD_LWU; xexp[0] = 64'h0000000080000000;
    xlo[1] = 3'd0; xty[1] = LD_LD;  xexp[1] = XRAW;
    xlo[2] = 3'd4; xty[2] = LD_LW;  xexp[2] = 64'hFFFFFFFF80000000;
    xlo[3] = 3'd7; xty[3] = LD_LB;  xexp[3] = 64'hFFFFFFFFFFFFFF80;
    xlo[4] = 3'd4; xty[4] = LD_LD;  xexp[4] = 64'h0;
    for (int k = 0; k < 6; k++) begin
      x_valid = k < 5;
      if (k < 5) begin
        x_lo = xlo[k]; x_ty = xty[k]; x_pc = 32'h2000 + 4*k;
      end
      @(posedge clk);
      #1;
      if (k < 5) begin
        chk("x_rf_we", 128'(x_we), 128'(1));
        chk("x_rf_wdata", 128'(x_wdata), 128'(xexp[k]));
      end else
        chk("x_rf_we_idle", 128'(x_we), 128'(0));
      if (k > 0) begin
        chk("x_trace_pc", 128'(x_dpc), 128'(32'h2000 + 4*(k-1)));
        chk("x_trace_wdata", 128'(x_dwdata),
            128'(xexp[k-1][31:0]));
      end
    end
    x_valid = 0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
